// File: rtl/cv32e40p_tmr_voter_mon.sv
// ============================================================================
// Module      : cv32e40p_tmr_voter_mon
// Description : Per-channel TMR majority voter with per-replica health
//               tracking, isolation of a faulty replica and DMR fallback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_tmr_voter_mon #(
    parameter int WIDTH      = 32,
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = 4,
    parameter int CLEAN_WIN  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [NUM_CH*WIDTH-1:0] rep0_i,
    input  logic [NUM_CH*WIDTH-1:0] rep1_i,
    input  logic [NUM_CH*WIDTH-1:0] rep2_i,
    input  logic                    clr_i,
    output logic                    valid_o,
    output logic [NUM_CH*WIDTH-1:0] data_o,
    output logic [NUM_CH-1:0]       mismatch_o,
    output logic [NUM_CH-1:0]       uncorr_o,
    output logic [2:0]              fault_sticky_o,
    output logic [2:0]              isolated_o,
    output logic                    dmr_mode_o,
    output logic [3*CNT_W-1:0]      err_cnt_o
);

    localparam int                 c_dw        = NUM_CH * WIDTH;
    localparam int                 c_cln_w     = $clog2(CLEAN_WIN + 1);
    localparam logic [CNT_W-1:0]   c_cnt_max   = '1;
    localparam logic [CNT_W-1:0]   c_thresh    = CNT_W'(ERR_THRESH);
    localparam logic [c_cln_w-1:0] c_clean_win = c_cln_w'(CLEAN_WIN);

    typedef enum logic [1:0] {
        ST_HEALTHY  = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_ISOLATED = 2'd2
    } rep_state_t;

    rep_state_t         r_state     [3];
    rep_state_t         w_state_nxt [3];
    logic [CNT_W-1:0]   r_cnt       [3];
    logic [CNT_W-1:0]   w_cnt_nxt   [3];
    logic [CNT_W-1:0]   w_cnt_inc   [3];
    logic [c_cln_w-1:0] r_clean     [3];
    logic [c_cln_w-1:0] w_clean_nxt [3];
    logic [c_cln_w-1:0] w_clean_inc [3];
    logic [2:0]         r_sticky;
    logic [2:0]         w_sticky_nxt;

    logic [2:0]         w_iso;
    logic               w_dmr;
    logic [2:0]         w_blame_ch  [NUM_CH];
    logic [2:0]         w_blame;
    logic [2:0]         w_hit;
    logic [2:0]         w_grant;
    logic [c_dw-1:0]    w_vdata;
    logic [NUM_CH-1:0]  w_mm;
    logic [NUM_CH-1:0]  w_unc;

    logic               r_valid;
    logic [c_dw-1:0]    r_data;
    logic [NUM_CH-1:0]  r_mm;
    logic [NUM_CH-1:0]  r_unc;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_iso[r] = (r_state[r] == ST_ISOLATED);
        end
    end

    assign w_dmr = |w_iso;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [WIDTH-1:0] w_a, w_b, w_c, w_x, w_y;
            logic             w_eq01, w_eq02, w_eq12;

            assign w_a = rep0_i[c*WIDTH +: WIDTH];
            assign w_b = rep1_i[c*WIDTH +: WIDTH];
            assign w_c = rep2_i[c*WIDTH +: WIDTH];

            // DMR pair: the two non-isolated replicas, lower index first
            always_comb begin
                w_x = w_a;
                w_y = w_b;
                if (w_iso[0]) begin
                    w_x = w_b;
                    w_y = w_c;
                end else if (w_iso[1]) begin
                    w_y = w_c;
                end
            end

            assign w_eq01 = (w_a == w_b);
            assign w_eq02 = (w_a == w_c);
            assign w_eq12 = (w_b == w_c);

            assign w_vdata[c*WIDTH +: WIDTH] = w_dmr ? w_x
                                             : ((w_a & w_b) | (w_a & w_c) | (w_b & w_c));
            assign w_mm[c]  = w_dmr ? (w_x != w_y) : !(w_eq01 && w_eq02);
            assign w_unc[c] = w_dmr ? (w_x != w_y) : (!w_eq01 && !w_eq02 && !w_eq12);
            assign w_blame_ch[c] = w_dmr ? 3'b000
                                 : {w_eq01 && !w_eq02, w_eq02 && !w_eq01, w_eq12 && !w_eq01};
        end
    endgenerate

    always_comb begin
        w_blame = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_blame = w_blame | w_blame_ch[c];
        end
        if (!valid_i) begin
            w_blame = '0;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_cnt_inc[r]   = (r_cnt[r] == c_cnt_max) ? c_cnt_max : r_cnt[r] + CNT_W'(1);
            w_clean_inc[r] = r_clean[r] + c_cln_w'(1);
            w_hit[r]       = w_blame[r] && (w_cnt_inc[r] >= c_thresh);
        end
    end

    // Only one replica may isolate per edge; lowest index wins
    assign w_grant[0] = w_hit[0];
    assign w_grant[1] = w_hit[1] && !w_hit[0];
    assign w_grant[2] = w_hit[2] && !(|w_hit[1:0]);

    always_comb begin
        w_sticky_nxt = r_sticky | w_blame;
        for (int r = 0; r < 3; r++) begin
            w_state_nxt[r] = r_state[r];
            w_cnt_nxt[r]   = r_cnt[r];
            w_clean_nxt[r] = r_clean[r];
            case (r_state[r])
                ST_HEALTHY, ST_SUSPECT: begin
                    if (w_blame[r]) begin
                        w_cnt_nxt[r]   = w_cnt_inc[r];
                        w_clean_nxt[r] = '0;
                        w_state_nxt[r] = w_grant[r] ? ST_ISOLATED : ST_SUSPECT;
                    end else if (valid_i && (r_state[r] == ST_SUSPECT)) begin
                        if (w_clean_inc[r] == c_clean_win) begin
                            w_state_nxt[r] = ST_HEALTHY;
                            w_cnt_nxt[r]   = '0;
                            w_clean_nxt[r] = '0;
                        end else begin
                            w_clean_nxt[r] = w_clean_inc[r];
                        end
                    end
                end
                default: begin
                end
            endcase
            if (clr_i) begin
                w_state_nxt[r] = ST_HEALTHY;
                w_cnt_nxt[r]   = '0;
                w_clean_nxt[r] = '0;
            end
        end
        if (clr_i) begin
            w_sticky_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                r_state[r] <= ST_HEALTHY;
                r_cnt[r]   <= '0;
                r_clean[r] <= '0;
            end
            r_sticky <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                r_state[r] <= w_state_nxt[r];
                r_cnt[r]   <= w_cnt_nxt[r];
                r_clean[r] <= w_clean_nxt[r];
            end
            r_sticky <= w_sticky_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_mm    <= '0;
            r_unc   <= '0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_data <= w_vdata;
                r_mm   <= w_mm;
                r_unc  <= w_unc;
            end else begin
                r_mm   <= '0;
                r_unc  <= '0;
            end
        end
    end

    generate
        for (genvar r = 0; r < 3; r++) begin : g_rep
            assign err_cnt_o[r*CNT_W +: CNT_W] = r_cnt[r];
            assign isolated_o[r]               = (r_state[r] == ST_ISOLATED);
        end
    endgenerate

    assign valid_o        = r_valid;
    assign data_o         = r_data;
    assign mismatch_o     = r_mm;
    assign uncorr_o       = r_unc;
    assign fault_sticky_o = r_sticky;
    assign dmr_mode_o     = |isolated_o;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_tmr_voter_mon.sv
// ============================================================================
// Module      : tb_cv32e40p_tmr_voter_mon
// Description : Scoreboard bench for the TMR voter/monitor, directed plus
//               randomized stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_tmr_voter_mon;

    localparam int WIDTH      = 32;
    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 8;
    localparam int ERR_THRESH = 4;
    localparam int CLEAN_WIN  = 16;
    localparam int DW         = WIDTH * NUM_CH;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic [DW-1:0]     rep0_i, rep1_i, rep2_i;
    logic              clr_i;
    logic              valid_o;
    logic [DW-1:0]     data_o;
    logic [NUM_CH-1:0] mismatch_o, uncorr_o;
    logic [2:0]        fault_sticky_o, isolated_o;
    logic              dmr_mode_o;
    logic [3*CNT_W-1:0] err_cnt_o;

    cv32e40p_tmr_voter_mon #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W),
        .ERR_THRESH(ERR_THRESH), .CLEAN_WIN(CLEAN_WIN)
    ) u_dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .rep0_i(rep0_i), .rep1_i(rep1_i), .rep2_i(rep2_i), .clr_i(clr_i),
        .valid_o(valid_o), .data_o(data_o), .mismatch_o(mismatch_o),
        .uncorr_o(uncorr_o), .fault_sticky_o(fault_sticky_o),
        .isolated_o(isolated_o), .dmr_mode_o(dmr_mode_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              valid;
        logic [DW-1:0]     data;
        logic [NUM_CH-1:0] mm;
        logic [NUM_CH-1:0] unc;
        logic [2:0]        sticky;
        logic [2:0]        iso;
        logic              dmr;
        logic [3*CNT_W-1:0] cnt;
    } exp_t;

    exp_t    q_exp[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    bit      stim_active = 0;

    // Reference model: health of each replica in plain integer terms
    int            m_mode  [3];   // 0 healthy, 1 suspect, 2 isolated
    int            m_cnt   [3];
    int            m_clean [3];
    bit            m_sticky[3];
    logic [DW-1:0] m_data;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 3; r++) begin
            m_mode[r] = 0; m_cnt[r] = 0; m_clean[r] = 0; m_sticky[r] = 0;
        end
        m_data = '0;
    endfunction

    function automatic void model_step(bit v, logic [DW-1:0] a, logic [DW-1:0] b,
                                       logic [DW-1:0] c, bit cl, bit rs);
        exp_t             e;
        logic [WIDTH-1:0] ch [3];
        logic [WIDTH-1:0] d;
        bit               blamed [3];
        int               iso_idx, p, q, ones;
        bit               granted;
        e.mm = '0; e.unc = '0;
        for (int r = 0; r < 3; r++) blamed[r] = 0;
        if (rs) begin
            model_reset();
        end else begin
            iso_idx = -1;
            for (int r = 0; r < 3; r++) if (m_mode[r] == 2) iso_idx = r;
            if (v) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    ch[0] = a[k*WIDTH +: WIDTH];
                    ch[1] = b[k*WIDTH +: WIDTH];
                    ch[2] = c[k*WIDTH +: WIDTH];
                    if (iso_idx < 0) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            ones = int'(ch[0][i]) + int'(ch[1][i]) + int'(ch[2][i]);
                            d[i] = (ones >= 2);
                        end
                        for (int r = 0; r < 3; r++)
                            if (ch[(r+1)%3] == ch[(r+2)%3] && ch[r] != ch[(r+1)%3])
                                blamed[r] = 1;
                        e.mm[k]  = !(ch[0] == ch[1] && ch[1] == ch[2]);
                        e.unc[k] = (ch[0] != ch[1]) && (ch[0] != ch[2]) && (ch[1] != ch[2]);
                    end else begin
                        p = (iso_idx == 0) ? 1 : 0;
                        q = (iso_idx == 2) ? 1 : 2;
                        d = ch[p];
                        e.mm[k]  = (ch[p] != ch[q]);
                        e.unc[k] = (ch[p] != ch[q]);
                    end
                    m_data[k*WIDTH +: WIDTH] = d;
                end
            end
            if (cl) begin
                model_reset_health();
            end else if (v) begin
                granted = 0;
                for (int r = 0; r < 3; r++) begin
                    if (m_mode[r] == 2) continue;
                    if (blamed[r]) begin
                        m_sticky[r] = 1;
                        if (m_cnt[r] < (1 << CNT_W) - 1) m_cnt[r]++;
                        m_clean[r] = 0;
                        if (m_cnt[r] >= ERR_THRESH && !granted) begin
                            m_mode[r] = 2;
                            granted = 1;
                        end else begin
                            m_mode[r] = 1;
                        end
                    end else if (m_mode[r] == 1) begin
                        m_clean[r]++;
                        if (m_clean[r] == CLEAN_WIN) begin
                            m_mode[r] = 0; m_cnt[r] = 0; m_clean[r] = 0;
                        end
                    end
                end
            end
        end
        e.valid = v && !rs;
        e.data  = m_data;
        e.dmr   = 0;
        for (int r = 0; r < 3; r++) begin
            e.sticky[r] = m_sticky[r];
            e.iso[r]    = (m_mode[r] == 2);
            e.dmr       = e.dmr | e.iso[r];
            e.cnt[r*CNT_W +: CNT_W] = CNT_W'(m_cnt[r]);
        end
        q_exp.push_back(e);
    endfunction

    function automatic void model_reset_health();
        for (int r = 0; r < 3; r++) begin
            m_mode[r] = 0; m_cnt[r] = 0; m_clean[r] = 0; m_sticky[r] = 0;
        end
    endfunction

    task automatic cycle(bit v, logic [DW-1:0] a, logic [DW-1:0] b,
                         logic [DW-1:0] c, bit cl, bit rs);
        @(negedge clk);
        valid_i = v; rep0_i = a; rep1_i = b; rep2_i = c; clr_i = cl; rst = rs;
        model_step(v, a, b, c, cl, rs);
        stim_active = 1;
    endtask

    // Monitor: one expected entry per clock edge while stimulus runs
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() == 0) begin
                if (stim_active) chk("scoreboard_underflow", 1, 0);
            end else begin
                e = q_exp.pop_front();
                chk("valid_o", valid_o, e.valid);
                chk("data_o", data_o, e.data);
                chk("mismatch_o", mismatch_o, e.mm);
                chk("uncorr_o", uncorr_o, e.unc);
                chk("fault_sticky_o", fault_sticky_o, e.sticky);
                chk("isolated_o", isolated_o, e.iso);
                chk("dmr_mode_o", dmr_mode_o, e.dmr);
                chk("err_cnt_o", err_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] base, a, b, c, mask;
        int            sel, rr, kk;
        model_reset();
        rst = 1; valid_i = 0; clr_i = 0; rep0_i = '0; rep1_i = '0; rep2_i = '0;
        base = {NUM_CH{32'hA5A5A5A5}};

        cycle(0, '0, '0, '0, 0, 1);
        cycle(0, '0, '0, '0, 0, 1);
        @(posedge clk); #2;
        chk("reset_valid", valid_o, 0);
        chk("reset_cnt", err_cnt_o, 0);

        repeat (20) cycle(1, base, base, base, 0, 0);
        @(posedge clk); #2;
        chk("clean_data", data_o, base);
        chk("clean_cnt", err_cnt_o, 0);

        b = base ^ (DW'(1) << (2*WIDTH));
        cycle(1, base, b, base, 0, 0);
        @(posedge clk); #2;
        chk("single_data", data_o, base);
        chk("single_mm", mismatch_o, 4'b0100);
        chk("single_unc", uncorr_o, 0);
        chk("single_cnt", err_cnt_o, 24'h000100);
        chk("single_sticky", fault_sticky_o, 3'b010);
        repeat (15) cycle(1, base, base, base, 0, 0);
        @(posedge clk); #2;
        chk("clean15_cnt", err_cnt_o, 24'h000100);
        cycle(1, base, base, base, 0, 0);
        @(posedge clk); #2;
        chk("clean16_cnt", err_cnt_o, 0);
        chk("clean16_sticky", fault_sticky_o, 3'b010);

        c = base ^ DW'(32'h0000_0F00);
        repeat (3) cycle(1, base, base, c, 0, 0);
        @(posedge clk); #2;
        chk("iso_3rd", isolated_o, 3'b000);
        cycle(1, base, base, c, 0, 0);
        @(posedge clk); #2;
        chk("iso_4th", isolated_o, 3'b100);
        chk("iso_dmr", dmr_mode_o, 1);
        chk("iso_cnt", err_cnt_o, 24'h040000);

        c = base ^ (DW'(32'hFFFF_FFFF) << (3*WIDTH));
        cycle(1, base, base, c, 0, 0);
        @(posedge clk); #2;
        chk("dmr_ignore_mm", mismatch_o, 0);
        chk("dmr_ignore_data", data_o, base);

        a = base; a[WIDTH +: WIDTH] = 32'h10;
        b = base; b[WIDTH +: WIDTH] = 32'h20;
        cycle(1, a, b, base, 0, 0);
        @(posedge clk); #2;
        chk("dmr_mm_data", data_o[WIDTH +: WIDTH], 32'h10);
        chk("dmr_mm_unc", uncorr_o, 4'b0010);
        chk("dmr_mm_cnt", err_cnt_o, 24'h040000);

        cycle(1, base, base, base, 1, 0);
        a = base ^ DW'(32'h1);
        cycle(1, a, base, base, 0, 0);
        @(posedge clk); #2;
        chk("pre_clr_cnt", err_cnt_o, 24'h000001);
        cycle(1, a, base, base, 1, 0);
        @(posedge clk); #2;
        chk("clr_cnt", err_cnt_o, 0);
        chk("clr_sticky", fault_sticky_o, 0);
        chk("clr_iso", isolated_o, 0);
        chk("clr_data", data_o, base);

        a = base; a[WIDTH-1:0] = 32'h1;
        b = base; b[WIDTH-1:0] = 32'h2;
        c = base; c[WIDTH-1:0] = 32'h4;
        cycle(1, a, b, c, 0, 0);
        @(posedge clk); #2;
        chk("triple_data", data_o[WIDTH-1:0], 32'h0);
        chk("triple_unc", uncorr_o, 4'b0001);
        chk("triple_cnt", err_cnt_o, 0);

        a = base ^ DW'(32'h8);
        b = base ^ (DW'(32'h8) << WIDTH);
        repeat (4) cycle(1, a, b, base, 0, 0);
        @(posedge clk); #2;
        chk("dual_iso", isolated_o, 3'b001);
        chk("dual_cnt", err_cnt_o, 24'h000404);
        cycle(1, base, base, base, 1, 0);

        cycle(0, a, b, c, 0, 0);
        @(posedge clk); #2;
        chk("invalid_valid", valid_o, 0);
        chk("invalid_mm", mismatch_o, 0);

        cycle(1, base, base, base, 0, 1);
        @(posedge clk); #2;
        chk("midrst_valid", valid_o, 0);

        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NUM_CH; k++) base[k*WIDTH +: WIDTH] = $urandom;
            a = base; b = base; c = base;
            sel = $urandom_range(0, 9);
            kk  = $urandom_range(0, NUM_CH-1);
            mask = '0;
            mask[kk*WIDTH +: WIDTH] = $urandom | 32'h1;
            rr = $urandom_range(0, 2);
            if (sel >= 6 && sel <= 7) begin
                if (rr == 0) a = a ^ mask; else if (rr == 1) b = b ^ mask; else c = c ^ mask;
            end else if (sel == 8) begin
                a = a ^ mask; b = b ^ (mask << 1) ^ mask ^ (DW'(1) << (kk*WIDTH + WIDTH - 1));
                c = c ^ (DW'(1) << (kk*WIDTH + 1));
                b[kk*WIDTH +: WIDTH] = ~a[kk*WIDTH +: WIDTH];
            end else if (sel == 9) begin
                b = b ^ mask; c = c ^ (mask << 2);
            end
            cycle(($urandom_range(0, 9) != 0), a, b, c,
                  ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
        end

        @(posedge clk); #3;
        stim_active = 0;
        chk("scoreboard_drained", DW'(q_exp.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
